// File: rtl/regfile_seq_pkg.sv
// ============================================================================
// Module      : regfile_seq_pkg
// Description : Shared types and defaults for the register-file sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_seq_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_LDI  = 3'b101,
    OP_ADDI = 3'b110,
    OP_MOV  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_seq_if.sv
// ============================================================================
// Module      : regfile_seq_if
// Description : Instruction handshake and register-file bus of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_seq_if
  import regfile_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              i_instr_valid;
  logic              o_instr_ready;
  opcode_e           i_opcode;
  logic [ADDR_W-1:0] i_rd;
  logic [ADDR_W-1:0] i_rs1;
  logic [ADDR_W-1:0] i_rs2;
  logic [WIDTH-1:0]  i_imm;
  logic [ADDR_W-1:0] o_reg_read_0;
  logic [ADDR_W-1:0] o_reg_read_1;
  logic [WIDTH-1:0]  i_port_read_0;
  logic [WIDTH-1:0]  i_port_read_1;
  logic [ADDR_W-1:0] o_reg_write;
  logic [WIDTH-1:0]  o_port_write;
  logic              o_write_enable;
  logic              o_done;
  logic              o_carry;
  logic              o_zero;

  // Sequencer side
  modport master (
    input  i_instr_valid, i_opcode, i_rd, i_rs1, i_rs2, i_imm,
    input  i_port_read_0, i_port_read_1,
    output o_instr_ready, o_reg_read_0, o_reg_read_1,
    output o_reg_write, o_port_write, o_write_enable,
    output o_done, o_carry, o_zero
  );

  // Instruction source and register file side
  modport slave (
    output i_instr_valid, i_opcode, i_rd, i_rs1, i_rs2, i_imm,
    output i_port_read_0, i_port_read_1,
    input  o_instr_ready, o_reg_read_0, o_reg_read_1,
    input  o_reg_write, o_port_write, o_write_enable,
    input  o_done, o_carry, o_zero
  );

endinterface

`default_nettype wire

// File: rtl/regfile_sequencer_alu_4.sv
// ============================================================================
// Module      : alu_4
// Description : Combinational ALU producing result and carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_4
  import regfile_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  input  wire logic [WIDTH-1:0] i_imm,
  input  wire opcode_e          i_opcode,
  output logic      [WIDTH-1:0] o_result,
  output logic                  o_carry
);

  logic [WIDTH:0] w_ext;

  // SUB: the extra MSB of the widened difference is the borrow (a < b)
  always_comb begin
    w_ext    = '0;
    o_result = '0;
    o_carry  = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_ext    = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_ext[WIDTH-1:0];
        o_carry  = w_ext[WIDTH];
      end
      OP_SUB: begin
        w_ext    = {1'b0, i_a} - {1'b0, i_b};
        o_result = w_ext[WIDTH-1:0];
        o_carry  = w_ext[WIDTH];
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_LDI:  o_result = i_imm;
      OP_ADDI: begin
        w_ext    = {1'b0, i_a} + {1'b0, i_imm};
        o_result = w_ext[WIDTH-1:0];
        o_carry  = w_ext[WIDTH];
      end
      OP_MOV:  o_result = i_a;
      default: o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
// Module      : regfile_sequencer
// Description : Serialised issue/read/execute/write-back controller for a
//               small register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst,
  regfile_seq_if.master  bus
);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_READ = S_READ;
  localparam logic [1:0] ST_EXEC = S_EXEC;
  localparam logic [1:0] ST_WB   = S_WB;

  logic [1:0]        r_state;
  opcode_e           r_opcode;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [WIDTH-1:0]  r_imm;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [WIDTH-1:0]  r_result;
  logic              r_res_carry;
  logic              r_res_zero;
  logic              r_carry;
  logic              r_zero;

  logic [WIDTH-1:0]  w_alu_result;
  logic              w_alu_carry;
  logic              w_in_wb;

  alu_4 #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .i_imm    (r_imm),
    .i_opcode (r_opcode),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_opcode    <= OP_ADD;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_result    <= '0;
      r_res_carry <= 1'b0;
      r_res_zero  <= 1'b0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_instr_valid) begin
            r_opcode <= bus.i_opcode;
            r_rd     <= bus.i_rd;
            r_rs1    <= bus.i_rs1;
            r_rs2    <= bus.i_rs2;
            r_imm    <= bus.i_imm;
            r_state  <= ST_READ;
          end
        end
        ST_READ: begin
          r_op_a  <= bus.i_port_read_0;
          r_op_b  <= bus.i_port_read_1;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result    <= w_alu_result;
          r_res_carry <= w_alu_carry;
          r_res_zero  <= (w_alu_result == '0);
          r_state     <= ST_WB;
        end
        ST_WB: begin
          r_carry <= r_res_carry;
          r_zero  <= r_res_zero;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A reset cycle must never write the register file
  assign w_in_wb = (r_state == ST_WB) && !i_rst;

  assign bus.o_instr_ready  = (r_state == ST_IDLE);
  assign bus.o_reg_read_0   = r_rs1;
  assign bus.o_reg_read_1   = r_rs2;
  assign bus.o_reg_write    = r_rd;
  assign bus.o_port_write   = r_result;
  assign bus.o_write_enable = w_in_wb;
  assign bus.o_done         = w_in_wb;
  assign bus.o_carry        = r_carry;
  assign bus.o_zero         = r_zero;

endmodule

`default_nettype wire
